param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 110 +++++++++++
 tb/tb_param_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Single-clock parameterised FIFO with registered read data,
// almost-full/almost-empty thresholds and sticky overflow/underflow.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [PW-1:0] AF_C = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C = PW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc;
  logic             rd_acc;

  // Pointer MSBs differ only when the writer has lapped the reader.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  assign count     = count_q;
  assign data_out  = dout_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      dout_d  = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ONE;
      if (rd_acc) begin
        rptr_d = rptr_q + ONE;
        dout_d = mem_q[rptr_q[AW-1:0]];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (wr_en && full && !rd_en);
      unf_d = unf_q | (rd_en && empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !clr && wr_acc)
      mem_q[wptr_q[AW-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo
// at WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int total = 0;
  int bad = 0;
  logic [7:0] last;

  param_fifo #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic w, input logic [7:0] d,
                      input logic r);
    wr_en = w; data_in = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(1'b1, 8'hEE, 1'b1);
    rstn = 1'b1;
    total++;
    if ({count, empty, full, almost_empty, almost_full,
         overflow, underflow} !== {5'd0, 6'b101000}) begin
      bad++;
      $display("FAIL reset_flags cnt=%0d e=%b f=%b ae=%b af=%b of=%b uf=%b",
               count, empty, full, almost_empty, almost_full,
               overflow, underflow);
    end
    total++;
    if (data_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_dout got=%h exp=00", data_out);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      total++;
      if (count !== 5'(i) || almost_full !== (i >= 14) ||
          almost_empty !== (i <= 2)) begin
        bad++;
        $display("FAIL fill_%0d cnt=%0d af=%b ae=%b", i, count,
                 almost_full, almost_empty);
      end
    end
    total++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      bad++;
      $display("FAIL fill_full full=%b empty=%b exp 1/0", full, empty);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++;
      if (data_out !== 8'(i) || count !== 5'(16 - i)) begin
        bad++;
        $display("FAIL drain_%0d got=%h exp=%h cnt=%0d", i,
                 data_out, 8'(i), count);
      end
    end
    total++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty empty=%b full=%b exp 1/0", empty, full);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    total++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      bad++;
      $display("FAIL ovf_set of=%b cnt=%0d exp 1/16", overflow, count);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++;
      if (data_out !== 8'(8'h20 + i)) begin
        bad++;
        $display("FAIL ovf_read_%0d got=%h exp=%h", i, data_out,
                 8'(8'h20 + i));
      end
    end
    total++;
    if (overflow !== 1'b1 || empty !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky of=%b empty=%b exp 1/1", overflow, empty);
    end
    clr = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr of=%b exp 0", overflow);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, 8'h9C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    last = 8'h9C;
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (underflow !== 1'b1 || data_out !== last || count !== 5'd0) begin
      bad++;
      $display("FAIL unf_set uf=%b dout=%h exp=%h cnt=%0d",
               underflow, data_out, last, count);
    end
    step(1'b1, 8'h55, 1'b1);
    total++;
    if (count !== 5'd1 || data_out !== last || underflow !== 1'b1) begin
      bad++;
      $display("FAIL unf_wr_rd cnt=%0d dout=%h exp 1/%h uf=%b",
               count, data_out, last, underflow);
    end
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (data_out !== 8'h55 || empty !== 1'b1) begin
      bad++;
      $display("FAIL unf_read got=%h exp=55 empty=%b", data_out, empty);
    end
    clr = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    clr = 1'b0;
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("FAIL unf_clr uf=%b exp 0", underflow);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    total++;
    if (data_out !== 8'h01 || count !== 5'd16 || full !== 1'b1 ||
        overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_rw dout=%h cnt=%0d full=%b of=%b exp 01/16/1/0",
               data_out, count, full, overflow);
    end
    for (int i = 2; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++;
      if (data_out !== 8'(i)) begin
        bad++;
        $display("FAIL full_rw_rd_%0d got=%h exp=%h", i, data_out, 8'(i));
      end
    end
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (data_out !== 8'h77 || count !== 5'd0) begin
      bad++;
      $display("FAIL full_rw_last got=%h exp=77 cnt=%0d", data_out, count);
    end
  endtask

  task automatic test_stream();
    logic [7:0] q[$];
    logic [7:0] exp;
    int mc;
    logic w, r, wa, ra;
    mc = 0;
    for (int k = 0; k < 46; k++) begin
      w = (k < 40);
      r = (k >= 3);
      wa = w && (mc < 16 || r);
      ra = r && (mc > 0);
      exp = 8'h00;
      if (ra) exp = q.pop_front();
      if (wa) q.push_back(8'(k * 7 + 3));
      mc = mc + (wa ? 1 : 0) - (ra ? 1 : 0);
      step(w, 8'(k * 7 + 3), r);
      if (ra) begin
        total++;
        if (data_out !== exp) begin
          bad++;
          $display("FAIL stream_%0d got=%h exp=%h", k, data_out, exp);
        end
      end
      total++;
      if (count !== 5'(mc) || count > 5'd16) begin
        bad++;
        $display("FAIL stream_cnt_%0d got=%0d exp=%0d", k, count, mc);
      end
    end
  endtask

  task automatic test_flush(input bit use_rst);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    if (use_rst) rstn = 1'b0;
    else clr = 1'b1;
    step(1'b1, 8'hFF, 1'b1);
    rstn = 1'b1; clr = 1'b0;
    total++;
    if ({count, empty, full, almost_full, overflow, underflow} !==
        {5'd0, 5'b10000} || data_out !== 8'h00) begin
      bad++;
      $display("FAIL flush_%0d cnt=%0d e=%b f=%b af=%b of=%b uf=%b dout=%h",
               use_rst, count, empty, full, almost_full, overflow,
               underflow, data_out);
    end
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (data_out !== 8'h3C || empty !== 1'b1) begin
      bad++;
      $display("FAIL flush_new_%0d got=%h exp=3C empty=%b", use_rst,
               data_out, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_rw();
    test_stream();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
